// File: rtl/seqgen_pkg.sv
// Shared definitions for the seqgen serial pattern transmitter.
package seqgen_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEND = 3'd1,
    GAP  = 3'd2,
    DONE = 3'd3
  } state_e;

  localparam logic [7:0] PAT_93 = 8'b10010011;

endpackage

// File: rtl/seqgen_shreg.sv
// Load/shift-left register with MSB tap; load takes priority over shift.
module seqgen_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d,
  output logic         msb
);

  logic [W-1:0] q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     q <= '0;
    else if (load)  q <= d;
    else if (shift) q <= q << 1;
  end

  assign msb = q[W-1];

endmodule

// File: rtl/seqgen_93.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, optionally
// repeated with zero-gap cycles between copies.
module seqgen_93
  import seqgen_pkg::*;
#(
  parameter int PAT_W   = 8,
  parameter int REP_W   = 4,
  parameter int GAP_CYC = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Abort,
  input  logic [PAT_W-1:0] Pattern,
  input  logic [REP_W-1:0] Reps,
  output logic             Out,
  output logic             Valid,
  output logic             Busy,
  output logic             Done
);

  localparam int BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(PAT_W - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  state_e           state;
  logic [PAT_W-1:0] pat_q;
  logic [REP_W-1:0] repcnt;
  logic [BW-1:0]    bitcnt;
  logic [GW-1:0]    gapcnt;
  logic             valid_q, busy_q, done_q;
  logic             sh_load, sh_shift, sh_msb;
  logic [PAT_W-1:0] sh_d;

  // Shift-register control follows the FSM transitions below: load on the
  // accepted Start, on a back-to-back repeat, and on leaving the gap.
  always_comb begin
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    sh_d     = pat_q;
    case (state)
      IDLE: if (Start && !Abort) begin
        sh_load = 1'b1;
        sh_d    = Pattern;
      end
      SEND: if (!Abort) begin
        if (bitcnt == BIT_LAST && repcnt != '0 && GAP_CYC == 0) sh_load = 1'b1;
        else                                                     sh_shift = 1'b1;
      end
      GAP: if (!Abort && gapcnt == GAP_LAST) sh_load = 1'b1;
      default: ;
    endcase
  end

  seqgen_shreg #(.W(PAT_W)) u_shreg (
    .clk   (Clk),
    .rst_n (Reset),
    .load  (sh_load),
    .shift (sh_shift),
    .d     (sh_d),
    .msb   (sh_msb)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      pat_q   <= '0;
      repcnt  <= '0;
      bitcnt  <= '0;
      gapcnt  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (Start && !Abort) begin
          pat_q   <= Pattern;
          repcnt  <= Reps;
          bitcnt  <= '0;
          gapcnt  <= '0;
          state   <= SEND;
          valid_q <= 1'b1;
          busy_q  <= 1'b1;
        end
        SEND: begin
          if (Abort) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (bitcnt == BIT_LAST) begin
            bitcnt <= '0;
            if (repcnt == '0) begin
              state   <= DONE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else if (GAP_CYC == 0) begin
              repcnt <= repcnt - REP_W'(1);
            end else begin
              state   <= GAP;
              valid_q <= 1'b0;
              gapcnt  <= '0;
            end
          end else begin
            bitcnt <= bitcnt + BW'(1);
          end
        end
        GAP: begin
          if (Abort) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (gapcnt == GAP_LAST) begin
            repcnt  <= repcnt - REP_W'(1);
            gapcnt  <= '0;
            state   <= SEND;
            valid_q <= 1'b1;
          end else begin
            gapcnt <= gapcnt + GW'(1);
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Out   = valid_q & sh_msb;
  assign Valid = valid_q;
  assign Busy  = busy_q;
  assign Done  = done_q;

endmodule
